// File: rtl/nis_cpu_uart_spi_slave.sv
// nis_cpu_uart_spi_slave: CPU-mapped SPI mode-0 slave with rx/tx holding registers, status and irq.
// Defining NIS_SPI_SLAVE_EOP_EN adds the eop-value register and end-of-packet detection.
module nis_cpu_uart_spi_slave #(
   parameter int DATABITS = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  mem_addr,
   input  logic        spi_select,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] data_from_cpu,
   output logic [31:0] data_to_cpu,
   output logic        irq,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        SS_n,
   output logic        MISO
);
   localparam int CW = $clog2(DATABITS + 1);
   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q, state_d;
   logic [1:0]          sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                sclk_prev_q, ss_prev_q;
   logic [DATABITS-1:0] shift_q, shift_d, tx_holding_q, tx_holding_d, load_val;
   logic [31:0]         rx_holding_q, rx_holding_d, data_to_cpu_q, data_to_cpu_d;
   logic [31:0]         eop_value_q, eop_value_d, rx_word, status;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [6:0]          ctrl_q, ctrl_d;
   logic                mosi_bit_q, mosi_bit_d, reload_q, reload_d, primed_q, primed_d;
   logic                rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, eop_q, eop_d;
   logic                strobe_q, strobe_d, irq_q, irq_d, miso_q, miso_d;
   logic                sclk_rise, sclk_fall, ss_fall, ss_rise, rd_stb, wr_stb, word_done;

   assign data_to_cpu = data_to_cpu_q;
   assign irq         = irq_q;
   assign MISO        = miso_q;

   always_comb begin
      sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
      sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
      ss_fall   = ~ss_sync_q[1] & ss_prev_q;
      ss_rise   = ss_sync_q[1] & ~ss_prev_q;
      rd_stb    = strobe_q & spi_select & ~read_n;
      wr_stb    = strobe_q & spi_select & ~write_n;
      word_done = (state_q == SHIFT) && !ss_rise && sclk_rise && (cnt_q == CW'(DATABITS - 1));
      rx_word   = 32'({shift_q[DATABITS-2:0], mosi_sync_q[1]});
      load_val  = primed_q ? tx_holding_q : '0;
      status    = {22'd0, eop_q, roe_q | toe_q, rrdy_q, ~primed_q, ~primed_q & (state_q == IDLE),
                   toe_q, roe_q, 3'd0};
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      mosi_bit_d    = mosi_bit_q;
      reload_d      = reload_q;
      primed_d      = primed_q;
      tx_holding_d  = tx_holding_q;
      rx_holding_d  = rx_holding_q;
      rrdy_d        = rrdy_q;
      roe_d         = roe_q;
      toe_d         = toe_q;
      eop_d         = eop_q;
      ctrl_d        = ctrl_q;
      eop_value_d   = eop_value_q;
      data_to_cpu_d = data_to_cpu_q;
      strobe_d      = spi_select & (~read_n | ~write_n) & ~strobe_q;
      // MOSI is captured on the rise and shifted in on the fall so MISO only moves on SCLK falls
      if (state_q == IDLE) begin
         if (ss_fall) begin
            state_d  = SHIFT;
            shift_d  = load_val;
            primed_d = 1'b0;
            cnt_d    = '0;
            reload_d = 1'b0;
         end
      end else if (ss_rise) begin
         state_d  = IDLE;
         cnt_d    = '0;
         reload_d = 1'b0;
      end else if (sclk_rise) begin
         mosi_bit_d = mosi_sync_q[1];
         cnt_d      = word_done ? '0 : cnt_q + 1'b1;
         reload_d   = word_done;
      end else if (sclk_fall) begin
         shift_d  = reload_q ? load_val : {shift_q[DATABITS-2:0], mosi_bit_q};
         primed_d = reload_q ? 1'b0 : primed_q;
         reload_d = 1'b0;
      end
      if (rd_stb && mem_addr == 3'd0) rrdy_d = 1'b0;
      if (wr_stb && mem_addr == 3'd2) begin
         rrdy_d = 1'b0;
         roe_d  = 1'b0;
         toe_d  = 1'b0;
         eop_d  = 1'b0;
      end
      if (wr_stb && mem_addr == 3'd3) ctrl_d = data_from_cpu[9:3];
      if (wr_stb && mem_addr == 3'd1) begin
         if (primed_q) toe_d = 1'b1;
         else begin
            tx_holding_d = data_from_cpu[DATABITS-1:0];
            primed_d     = 1'b1;
         end
      end
      // setting events come after the clears so a coincident word or overrun wins
      if (word_done) begin
         rx_holding_d = rx_word;
         rrdy_d       = 1'b1;
         if (rrdy_q) roe_d = 1'b1;
      end
`ifdef NIS_SPI_SLAVE_EOP_EN
      if (wr_stb && mem_addr == 3'd6) eop_value_d = data_from_cpu;
      if ((word_done && rx_word == eop_value_q) ||
          (wr_stb && mem_addr == 3'd1 && data_from_cpu == eop_value_q)) eop_d = 1'b1;
`else
      eop_value_d = '0;
      eop_d       = 1'b0;
      ctrl_d[6]   = 1'b0;
`endif
      if (rd_stb)
         data_to_cpu_d = mem_addr == 3'd0 ? rx_holding_q :
                         mem_addr == 3'd2 ? status :
                         mem_addr == 3'd3 ? {22'd0, ctrl_q, 3'd0} :
                         mem_addr == 3'd6 ? eop_value_q : '0;
      irq_d  = |(status[9:3] & ctrl_q & 7'b1111011);
      miso_d = (state_d == SHIFT) ? shift_d[DATABITS-1] : 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         sclk_sync_q   <= 2'b00;
         ss_sync_q     <= 2'b11;
         mosi_sync_q   <= 2'b00;
         sclk_prev_q   <= 1'b0;
         ss_prev_q     <= 1'b1;
         shift_q       <= '0;
         tx_holding_q  <= '0;
         rx_holding_q  <= '0;
         data_to_cpu_q <= '0;
         eop_value_q   <= '0;
         cnt_q         <= '0;
         ctrl_q        <= '0;
         mosi_bit_q    <= 1'b0;
         reload_q      <= 1'b0;
         primed_q      <= 1'b0;
         rrdy_q        <= 1'b0;
         roe_q         <= 1'b0;
         toe_q         <= 1'b0;
         eop_q         <= 1'b0;
         strobe_q      <= 1'b0;
         irq_q         <= 1'b0;
         miso_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= {sclk_sync_q[0], SCLK};
         ss_sync_q     <= {ss_sync_q[0], SS_n};
         mosi_sync_q   <= {mosi_sync_q[0], MOSI};
         sclk_prev_q   <= sclk_sync_q[1];
         ss_prev_q     <= ss_sync_q[1];
         shift_q       <= shift_d;
         tx_holding_q  <= tx_holding_d;
         rx_holding_q  <= rx_holding_d;
         data_to_cpu_q <= data_to_cpu_d;
         eop_value_q   <= eop_value_d;
         cnt_q         <= cnt_d;
         ctrl_q        <= ctrl_d;
         mosi_bit_q    <= mosi_bit_d;
         reload_q      <= reload_d;
         primed_q      <= primed_d;
         rrdy_q        <= rrdy_d;
         roe_q         <= roe_d;
         toe_q         <= toe_d;
         eop_q         <= eop_d;
         strobe_q      <= strobe_d;
         irq_q         <= irq_d;
         miso_q        <= miso_d;
      end
   end
endmodule
